// File: rtl/bnn_pkg.sv
// Shared types and defaults for the BNN inference controller.
// Imported by the controller top and its retiming pipeline.
package bnn_pkg;

  localparam int BNN_IMG_W = 904;
  localparam int BNN_PAD_W = 4;
  localparam int BNN_RES_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } bnn_ctrl_state_t;

  // All-ones result marker; callers cast to their result width.
  function automatic logic [31:0] BNN_RES_ERR(input int w);
    BNN_RES_ERR = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/bnn_ce_pipe.sv
// Clock-enabled delay line with a valid token and synchronous flush.
// Data only advances behind a valid token, so it freezes once drained.
module bnn_ce_pipe import bnn_pkg::*; #(
  parameter int W      = 8,
  parameter int STAGES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [STAGES-1:0] v_q;
  logic [W-1:0]      d_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= '0;
      end
    end else if (flush) begin
      v_q <= '0;
    end else if (ce) begin
      v_q[0] <= in_valid;
      if (in_valid) d_q[0] <= in_data;
      for (int i = 1; i < STAGES; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];

endmodule

// File: rtl/bnn_infer_ctrl.sv
// Inference controller: snapshots an image, retimes it to the core,
// supervises the core with a timeout and retimes the result back.
module bnn_infer_ctrl import bnn_pkg::*; #(
  parameter int IMG_W    = BNN_IMG_W,
  parameter int PAD_W    = BNN_PAD_W,
  parameter int RES_W    = BNN_RES_W,
  parameter int STAGES   = 3,
  parameter int DIV_LOG2 = 2,
  parameter int TIMEOUT  = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IMG_W-1:0]       img_in,
  input  logic                   img_buffer_full,
  input  logic                   bnn_enable,
  input  logic                   bnn_clear,
  output logic [RES_W-1:0]       result_out,
  output logic                   result_ready,
  output logic                   result_err,
  output logic                   busy,
  output logic [IMG_W-PAD_W-1:0] core_img,
  output logic                   core_start,
  input  logic [RES_W-1:0]       core_result,
  input  logic                   core_done
);

  localparam int CW = IMG_W - PAD_W;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic ce;

  generate
    if (DIV_LOG2 == 0) begin : g_nodiv
      assign ce = 1'b1;
    end else begin : g_div
      logic [DIV_LOG2-1:0] div_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_q + DIV_LOG2'(1);
      end
      assign ce = (div_q == '0);
    end
  endgenerate

  bnn_ctrl_state_t state_q;
  logic [CW-1:0]    snap_q;
  logic             lpend_q;
  logic             rpend_q;
  logic [RES_W-1:0] res_q;
  logic             rerr_q;
  logic [TW-1:0]    tmo_q;
  logic             start_q;
  logic             ready_q;
  logic             err_q;
  logic [RES_W-1:0] out_q;

  logic             l_valid;
  logic [CW-1:0]    l_data;
  logic             r_valid;
  logic [RES_W:0]   r_data;
  logic             abort;
  logic             l_flush;
  logic             r_flush;
  logic             unused_pad;

  assign unused_pad = ^img_in[PAD_W-1:0];

  assign abort = bnn_clear
               && (state_q == ST_LAUNCH
                || state_q == ST_RUN
                || state_q == ST_DRAIN);
  assign l_flush = abort
                || (state_q == ST_LAUNCH && l_valid);
  assign r_flush = abort
                || (state_q == ST_DRAIN && r_valid);

  bnn_ce_pipe #(.W(CW), .STAGES(STAGES)) u_lpipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .flush     (l_flush),
    .in_valid  (lpend_q),
    .in_data   (snap_q),
    .out_valid (l_valid),
    .out_data  (l_data)
  );

  bnn_ce_pipe #(.W(RES_W+1), .STAGES(STAGES)) u_rpipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .flush     (r_flush),
    .in_valid  (rpend_q),
    .in_data   ({res_q, rerr_q}),
    .out_valid (r_valid),
    .out_data  (r_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      lpend_q <= 1'b0;
      rpend_q <= 1'b0;
      res_q   <= '0;
      rerr_q  <= 1'b0;
      tmo_q   <= '0;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      // Pending tokens enter their pipe on the first ce after being set.
      if (ce) begin
        lpend_q <= 1'b0;
        rpend_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (img_buffer_full && bnn_enable) begin
            snap_q  <= img_in[IMG_W-1:PAD_W];
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            lpend_q <= 1'b1;
            state_q <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (bnn_clear) begin
            lpend_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (l_valid) begin
            start_q <= 1'b1;
            tmo_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bnn_clear) begin
            start_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (core_done) begin
            res_q   <= core_result;
            rerr_q  <= 1'b0;
            rpend_q <= 1'b1;
            start_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else if (tmo_q == TW'(TIMEOUT-1)) begin
            res_q   <= RES_W'(BNN_RES_ERR(RES_W));
            rerr_q  <= 1'b1;
            rpend_q <= 1'b1;
            start_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_DRAIN: begin
          if (bnn_clear) begin
            rpend_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (r_valid) begin
            out_q   <= r_data[RES_W:1];
            err_q   <= r_data[0];
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bnn_clear) begin
            ready_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result_out   = out_q;
  assign result_ready = ready_q;
  assign result_err   = err_q;
  assign busy         = (state_q != ST_IDLE);
  assign core_img     = l_data;
  assign core_start   = start_q;

endmodule

// File: tb/tb_bnn_infer_ctrl.sv
// Randomised bench for bnn_infer_ctrl: one undivided and one div-by-4
// instance, checked against latency/result rules computed here.
module tb_bnn_infer_ctrl;

  localparam int IW  = 904;
  localparam int PW  = 4;
  localparam int CW  = IW - PW;
  localparam int S   = 3;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] img   [2];
  logic          full  [2];
  logic          en    [2];
  logic          clr   [2];
  logic          done  [2];
  logic [3:0]    cres  [2];
  logic [3:0]    rout  [2];
  logic          rrdy  [2];
  logic          rerr  [2];
  logic          bsy   [2];
  logic          cst   [2];
  logic [CW-1:0] cimg  [2];

  int nchk  = 0;
  int nfail = 0;
  int ecnt  = 0;

  always @(posedge clk) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  bnn_infer_ctrl #(
    .IMG_W(IW), .PAD_W(PW), .RES_W(4), .STAGES(S),
    .DIV_LOG2(0), .TIMEOUT(TMO)
  ) u_d0 (
    .clk(clk), .rst_n(rst_n), .img_in(img[0]),
    .img_buffer_full(full[0]), .bnn_enable(en[0]),
    .bnn_clear(clr[0]), .result_out(rout[0]),
    .result_ready(rrdy[0]), .result_err(rerr[0]),
    .busy(bsy[0]), .core_img(cimg[0]),
    .core_start(cst[0]), .core_result(cres[0]),
    .core_done(done[0])
  );

  bnn_infer_ctrl #(
    .IMG_W(IW), .PAD_W(PW), .RES_W(4), .STAGES(S),
    .DIV_LOG2(2), .TIMEOUT(TMO)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .img_in(img[1]),
    .img_buffer_full(full[1]), .bnn_enable(en[1]),
    .bnn_clear(clr[1]), .result_out(rout[1]),
    .result_ready(rrdy[1]), .result_err(rerr[1]),
    .busy(bsy[1]), .core_img(cimg[1]),
    .core_start(cst[1]), .core_result(cres[1]),
    .core_done(done[1])
  );

  task automatic chk(input string tag,
                     input logic [1023:0] got,
                     input logic [1023:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int period(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Edges after n0 until the output changes: S ce pulses strictly
  // after n0, then one clock to register the result.
  function automatic int exp_lat(input int n0, input int p);
    int first;
    first = (n0 / p + 1) * p;
    return first + (S - 1) * p + 1 - n0;
  endfunction

  function automatic logic [IW-1:0] rimg();
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < 29; i++) r = (r << 32) | IW'($urandom());
    return r;
  endfunction

  function automatic logic [CW-1:0] strip(input logic [IW-1:0] v);
    return v[IW-1:PW];
  endfunction

  // kind 0: core_start high, 1: result_ready high, 2: core_start low
  task automatic wait_for(input int d, input int kind,
                          input int maxc, output int edge_i);
    edge_i = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if ((kind == 0 && cst[d] === 1'b1)
       || (kind == 1 && rrdy[d] === 1'b1)
       || (kind == 2 && cst[d] === 1'b0)) begin
        edge_i = ecnt - 1;
        break;
      end
    end
    if (edge_i < 0) begin
      nchk++;
      nfail++;
      $display("FAIL wait dut=%0d kind=%0d expired", d, kind);
    end
  endtask

  task automatic request(input int d, input logic [IW-1:0] v,
                         output int na);
    img[d] = v;
    full[d] = 1'b1;
    en[d] = 1'b1;
    na = ecnt;
    @(negedge clk);
    full[d] = 1'b0;
    en[d] = 1'b0;
    img[d] = rimg();
    chk("busy_after_accept", bsy[d], 1'b1);
  endtask

  task automatic launch(input int d, input logic [IW-1:0] v,
                        output int rise);
    int na;
    request(d, v, na);
    chk("start_early", cst[d], 1'b0);
    wait_for(d, 0, 64, rise);
    chk("launch_lat", rise - na, exp_lat(na, period(d)));
    chk("core_img", cimg[d], strip(v));
  endtask

  task automatic give_done(input int d, input logic [3:0] r,
                           output int nd);
    done[d] = 1'b1;
    cres[d] = r;
    nd = ecnt;
    @(negedge clk);
    done[d] = 1'b0;
    cres[d] = 4'($urandom());
    chk("start_drop", cst[d], 1'b0);
  endtask

  task automatic expect_result(input int d, input int n0,
                               input logic [3:0] r,
                               input logic e);
    int rdy;
    wait_for(d, 1, 64, rdy);
    chk("return_lat", rdy - n0, exp_lat(n0, period(d)));
    chk("result_out", rout[d], r);
    chk("result_err", rerr[d], e);
    repeat (3) @(negedge clk);
    chk("hold_ready", rrdy[d], 1'b1);
    chk("hold_busy", bsy[d], 1'b1);
  endtask

  task automatic clear(input int d, input logic [3:0] r);
    clr[d] = 1'b1;
    @(negedge clk);
    clr[d] = 1'b0;
    chk("clr_busy", bsy[d], 1'b0);
    chk("clr_ready", rrdy[d], 1'b0);
    chk("clr_keep", rout[d], r);
  endtask

  task automatic watch_quiet(input int d, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seen = seen | cst[d] | rrdy[d] | bsy[d];
    end
    chk("quiet_after_abort", seen, 1'b0);
  endtask

  task automatic nominal(input int d, input int gap, input int dly);
    logic [IW-1:0] v;
    logic [3:0] r;
    int rise, nd;
    v = rimg();
    r = 4'($urandom());
    launch(d, v, rise);
    repeat (dly) @(negedge clk);
    chk("run_start", cst[d], 1'b1);
    give_done(d, r, nd);
    expect_result(d, nd, r, 1'b0);
    clear(d, r);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int rise, fall, nd, na;
    logic [IW-1:0] v;
    for (int d = 0; d < 2; d++) begin
      img[d] = '0; full[d] = 0; en[d] = 0;
      clr[d] = 0; done[d] = 0; cres[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_out", rout[d], 4'h0);
      chk("rst_flags", {rrdy[d], rerr[d], bsy[d], cst[d]}, 4'h0);
      chk("rst_img", cimg[d], '0);
    end
    rst_n = 1'b1;

    for (int it = 0; it < 6; it++) nominal(0, $urandom_range(0, 4),
                                           $urandom_range(0, 12));
    // Cover every accept phase relative to the divider.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 8 && (ecnt % 4) != ph; i++) @(negedge clk);
      chk("phase_align", ecnt % 4, ph);
      nominal(1, 0, $urandom_range(0, 12));
    end

    for (int d = 0; d < 2; d++) begin
      launch(d, rimg(), rise);
      wait_for(d, 2, 64, fall);
      chk("timeout_edge", fall - rise, TMO);
      expect_result(d, fall, 4'hF, 1'b1);
      clear(d, 4'hF);

      launch(d, rimg(), rise);
      for (int i = 0; i < 64 && ecnt < rise + TMO; i++) @(negedge clk);
      give_done(d, 4'd3, nd);
      chk("tie_edge", nd - rise, TMO);
      expect_result(d, nd, 4'd3, 1'b0);

      // Clear and request together in DONE: request dropped.
      clr[d] = 1'b1; full[d] = 1'b1; en[d] = 1'b1;
      @(negedge clk);
      clr[d] = 1'b0; full[d] = 1'b0; en[d] = 1'b0;
      chk("clr_req_busy", bsy[d], 1'b0);
      nominal(d, 1, 2);

      request(d, rimg(), na);
      clr[d] = 1'b1;
      @(negedge clk);
      clr[d] = 1'b0;
      chk("abort_l_busy", bsy[d], 1'b0);
      watch_quiet(d, 24);

      v = rimg();
      launch(d, v, rise);
      img[d] = rimg(); full[d] = 1'b1; en[d] = 1'b1;
      @(negedge clk);
      full[d] = 1'b0; en[d] = 1'b0;
      chk("ign_req_start", cst[d], 1'b1);
      chk("ign_req_img", cimg[d], strip(v));
      clr[d] = 1'b1;
      @(negedge clk);
      clr[d] = 1'b0;
      chk("abort_r_start", cst[d], 1'b0);
      chk("abort_r_busy", bsy[d], 1'b0);
      watch_quiet(d, 24);
    end

    // Reset while draining a result.
    launch(0, rimg(), rise);
    give_done(0, 4'd9, nd);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_mid_out", rout[d], 4'h0);
      chk("rst_mid_flags", {rrdy[d], rerr[d], bsy[d], cst[d]}, 4'h0);
      chk("rst_mid_img", cimg[d], '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nominal(0, 0, 3);
    nominal(1, 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1, "bench time limit");
  end

endmodule
